// File: rtl/bcd_enc_pkg.sv
// ---------------------------------------------------------------------------
// bcd_enc_pkg
// Shared types and constants for the binary-to-BCD display encoder.
//   bcd_enc_state_t : conversion FSM states (IDLE -> CONV -> FIX -> IDLE)
//   BCD_BLANK       : digit code the display controller renders as blank
//   NUM_DIGITS      : digits shown on the 7-segment display
//   BCD_FIELD_W     : width of the double-dabble BCD scratch field
//                     (five digits, enough for any 16-bit input)
// ---------------------------------------------------------------------------
package bcd_enc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIX  = 2'd2
    } bcd_enc_state_t;

    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam int         NUM_DIGITS  = 4;
    localparam int         BCD_FIELD_W = 20;

endpackage

// File: rtl/bcd_value_encoder_if.sv
// ---------------------------------------------------------------------------
// bcd_value_encoder_if
// Request/result bundle between the multimeter datapath and the encoder.
//   start   : conversion request (master -> encoder)
//   bin_in  : unsigned 16-bit value to display
//   dp_en   : decimal point enable
//   dp_sel  : digit index carrying the dot (3 = leftmost)
//   busy    : conversion in progress
//   done    : one-cycle pulse, results below are new
//   ovf     : held result is an overflow
//   bcd_out : {d3,d2,d1,d0}, d3 leftmost in bits 15:12
//   dp_out  : one-hot dot vector, bit i = digit i
//
// Handshake: start is only looked at while busy is low. A rising clock edge
// with start high and busy low accepts the request and captures bin_in,
// dp_en and dp_sel on that same edge; busy then stays high until the edge
// that raises done. start while busy is dropped, never queued. bcd_out,
// dp_out and ovf change only on the edge that raises done and otherwise hold.
// ---------------------------------------------------------------------------
interface bcd_value_encoder_if;

    logic        start;
    logic [15:0] bin_in;
    logic        dp_en;
    logic [1:0]  dp_sel;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [15:0] bcd_out;
    logic [3:0]  dp_out;

    modport master (
        output start, bin_in, dp_en, dp_sel,
        input  busy, done, ovf, bcd_out, dp_out
    );

    modport slave (
        input  start, bin_in, dp_en, dp_sel,
        output busy, done, ovf, bcd_out, dp_out
    );

endinterface

// File: rtl/bcd_dabble_step.sv
// ---------------------------------------------------------------------------
// bcd_dabble_step
// Combinational add-3 stage of the double-dabble algorithm: every 4-bit
// digit of the BCD field that is 5 or more gets 3 added, so the following
// left shift carries correctly into the next decimal digit.
//   field_in  : BCD scratch field before adjustment
//   field_out : adjusted field, ready to be shifted
// ---------------------------------------------------------------------------
module bcd_dabble_step
    import bcd_enc_pkg::*;
(
    input  logic [BCD_FIELD_W-1:0] field_in,
    output logic [BCD_FIELD_W-1:0] field_out
);

    always_comb begin
        field_out = field_in;
        for (int i = 0; i < BCD_FIELD_W / 4; i++) begin
            if (field_in[i*4 +: 4] >= 4'd5) begin
                field_out[i*4 +: 4] = field_in[i*4 +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/bcd_value_encoder.sv
// ---------------------------------------------------------------------------
// bcd_value_encoder
// Sequential binary-to-BCD encoder feeding the 4-digit 7-segment controller.
// One conversion takes 16 double-dabble cycles plus one fix-up cycle, after
// which overflow substitution, decimal point placement and optional
// leading-zero blanking are registered onto the held outputs.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   bus       : request/result bundle (slave side)
//   fsm_state : current FSM state, for observation only
// Parameters:
//   BIN_W    : binary input width (the 20-bit BCD field assumes 16)
//   LZ_BLANK : 1 = leading zero digits shown as BCD_BLANK
//   MAX_VAL  : largest displayable value, anything above is overflow
// ---------------------------------------------------------------------------
module bcd_value_encoder
    import bcd_enc_pkg::*;
#(
    parameter int BIN_W    = 16,
    parameter bit LZ_BLANK = 1'b1,
    parameter int MAX_VAL  = 9999
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_value_encoder_if.slave   bus,
    output bcd_enc_state_t       fsm_state
);

    localparam int               SR_W    = BCD_FIELD_W + BIN_W;
    localparam int               CNT_W   = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(BIN_W - 1);
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

    bcd_enc_state_t          state;
    logic [SR_W-1:0]         sr;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf_pend;
    logic                    dp_en_q;
    logic [1:0]              dp_sel_q;

    logic                    busy_q;
    logic                    done_q;
    logic                    ovf_q;
    logic [15:0]             bcd_q;
    logic [3:0]              dp_q;

    logic [BCD_FIELD_W-1:0]  dabbled;
    logic [SR_W-1:0]         adjusted;
    logic [15:0]             digits;
    logic [15:0]             shown;
    logic                    lead_zero;

    bcd_dabble_step u_step (
        .field_in  (sr[SR_W-1:BIN_W]),
        .field_out (dabbled)
    );

    assign adjusted = {dabbled, sr[BIN_W-1:0]};

    // After the last shift the four displayed digits sit just above the
    // binary part; the fifth digit only matters for overflow and is dropped.
    // A digit is blanked while every digit from the left down to it is zero,
    // unless it carries the dot or lies to the right of the dot.
    always_comb begin
        digits    = sr[BIN_W+15:BIN_W];
        shown     = digits;
        lead_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead_zero = lead_zero && (digits[i*4 +: 4] == 4'd0);
            if (LZ_BLANK && lead_zero && (!dp_en_q || (2'(i) > dp_sel_q))) begin
                shown[i*4 +: 4] = BCD_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            dp_en_q  <= 1'b0;
            dp_sel_q <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            bcd_q    <= 16'hFFFF;
            dp_q     <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sr       <= {{BCD_FIELD_W{1'b0}}, bus.bin_in};
                        ovf_pend <= (bus.bin_in > MAX_BIN);
                        dp_en_q  <= bus.dp_en;
                        dp_sel_q <= bus.dp_sel;
                        cnt      <= '0;
                        busy_q   <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    sr  <= adjusted << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_END) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (ovf_pend) begin
                        bcd_q <= 16'hFFFF;
                        dp_q  <= 4'd0;
                        ovf_q <= 1'b1;
                    end else begin
                        bcd_q <= shown;
                        dp_q  <= dp_en_q ? (4'd1 << dp_sel_q) : 4'd0;
                        ovf_q <= 1'b0;
                    end
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ovf     = ovf_q;
    assign bus.bcd_out = bcd_q;
    assign bus.dp_out  = dp_q;
    assign fsm_state   = state;

endmodule

// File: tb/tb_bcd_value_encoder.sv
// ---------------------------------------------------------------------------
// tb_bcd_value_encoder
// Drives two encoders with identical requests, one with leading-zero
// blanking and one without, and compares every done result against a
// decimal reference model computed with division/modulo arithmetic.
// ---------------------------------------------------------------------------
module tb_bcd_value_encoder;
    import bcd_enc_pkg::*;

    logic clk;
    logic rst_n;
    bcd_enc_state_t state_a;
    bcd_enc_state_t state_b;

    bcd_value_encoder_if bus_a ();
    bcd_value_encoder_if bus_b ();

    assign bus_b.start  = bus_a.start;
    assign bus_b.bin_in = bus_a.bin_in;
    assign bus_b.dp_en  = bus_a.dp_en;
    assign bus_b.dp_sel = bus_a.dp_sel;

    bcd_value_encoder #(.BIN_W(16), .LZ_BLANK(1'b1), .MAX_VAL(9999)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_a),
        .fsm_state (state_a)
    );

    bcd_value_encoder #(.BIN_W(16), .LZ_BLANK(1'b0), .MAX_VAL(9999)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_b),
        .fsm_state (state_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [20:0] exp_q[$];
    logic [20:0] exp_b_q[$];
    logic [20:0] last_a;
    logic [20:0] last_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Result word {ovf, dp_out, bcd_out} worked out from decimal arithmetic.
    function automatic logic [20:0] model(input int v, input bit en, input int sel, input bit lz);
        logic [15:0] digs;
        logic [3:0]  dots;
        int p;
        int d;
        digs = '0;
        if (v > 9999) return {1'b1, 4'b0000, 16'hFFFF};
        p = 1;
        for (int i = 0; i < 4; i++) begin
            d = (v / p) % 10;
            // v < 10^i means digit i and all digits left of it are zero
            if (lz && i > 0 && v < p && (!en || i > sel)) d = 15;
            digs[i*4 +: 4] = 4'(d);
            p = p * 10;
        end
        dots = en ? 4'(1 << sel) : 4'b0000;
        return {1'b0, dots, digs};
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus_a.done) begin
            if (exp_q.size() == 0) check("spurious_done_a", 32'(bus_a.done), 32'd0);
            else check("result_a", 32'({bus_a.ovf, bus_a.dp_out, bus_a.bcd_out}), 32'(exp_q.pop_front()));
        end
        if (rst_n && bus_b.done) begin
            if (exp_b_q.size() == 0) check("spurious_done_b", 32'(bus_b.done), 32'd0);
            else check("result_b", 32'({bus_b.ovf, bus_b.dp_out, bus_b.bcd_out}), 32'(exp_b_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus_a.start  = 1'b0;
            bus_a.bin_in = 16'($urandom);
            bus_a.dp_en  = 1'($urandom_range(0, 1));
            bus_a.dp_sel = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic run_conv(input int v, input bit en, input int sel, input bit noise);
        int cycles;
        @(negedge clk);
        bus_a.start  = 1'b1;
        bus_a.bin_in = 16'(v);
        bus_a.dp_en  = en;
        bus_a.dp_sel = 2'(sel);
        last_a = model(v, en, sel, 1'b1);
        last_b = model(v, en, sel, 1'b0);
        exp_q.push_back(last_a);
        exp_b_q.push_back(last_b);
        @(posedge clk);
        #1;
        check("busy_after_accept", 32'(bus_a.busy), 32'd1);
        cycles = 0;
        while (!bus_a.done && cycles < 40) begin
            @(negedge clk);
            if (noise) begin
                // stray requests and changing inputs while busy must be ignored
                bus_a.start  = (cycles == 4) ? 1'b1 : 1'($urandom_range(0, 1));
                bus_a.bin_in = (cycles == 4) ? 16'd8888 : 16'($urandom);
                bus_a.dp_en  = 1'($urandom_range(0, 1));
                bus_a.dp_sel = 2'($urandom_range(0, 3));
            end else begin
                bus_a.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        check("latency", 32'(cycles), 32'd17);
        check("busy_at_done", 32'(bus_a.busy), 32'd0);
        @(negedge clk);
        bus_a.start = 1'b0;
        idle(3);
        check("hold_a", 32'({bus_a.ovf, bus_a.dp_out, bus_a.bcd_out}), 32'(last_a));
        check("hold_b", 32'({bus_b.ovf, bus_b.dp_out, bus_b.bcd_out}), 32'(last_b));
    endtask

    // Counts edges from the previous observation point until done is seen.
    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!bus_a.done && cycles < 40);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int v;
        rst_n        = 1'b0;
        bus_a.start  = 1'b0;
        bus_a.bin_in = 16'd0;
        bus_a.dp_en  = 1'b0;
        bus_a.dp_sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_bcd", 32'(bus_a.bcd_out), 32'hFFFF);
        check("reset_dp", 32'(bus_a.dp_out), 32'd0);
        check("reset_busy", 32'(bus_a.busy), 32'd0);
        check("reset_done", 32'(bus_a.done), 32'd0);
        check("reset_ovf", 32'(bus_a.ovf), 32'd0);
        check("reset_state", 32'(state_a), 32'(IDLE));
        check("reset_bcd_b", 32'(bus_b.bcd_out), 32'hFFFF);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // directed values
        run_conv(1234, 1'b0, 0, 1'b0);
        run_conv(5, 1'b1, 2, 1'b0);
        run_conv(0, 1'b0, 0, 1'b0);
        run_conv(70, 1'b1, 0, 1'b0);
        run_conv(10000, 1'b1, 1, 1'b0);
        run_conv(9999, 1'b0, 0, 1'b0);
        run_conv(65535, 1'b1, 3, 1'b0);
        run_conv(9, 1'b1, 3, 1'b0);
        run_conv(4321, 1'b0, 0, 1'b1);

        // start held high: back-to-back conversions
        @(negedge clk);
        bus_a.start  = 1'b1;
        bus_a.bin_in = 16'd1357;
        bus_a.dp_en  = 1'b1;
        bus_a.dp_sel = 2'd1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(model(1357, 1'b1, 1, 1'b1));
            exp_b_q.push_back(model(1357, 1'b1, 1, 1'b0));
        end
        @(posedge clk);
        #1;
        cyc = 0;
        while (!bus_a.done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("b2b_first_latency", 32'(cyc), 32'd17);
        wait_done(cyc);
        check("b2b_period_1", 32'(cyc), 32'd18);
        wait_done(cyc);
        check("b2b_period_2", 32'(cyc), 32'd18);
        @(negedge clk);
        bus_a.start = 1'b0;
        idle(20);
        check("b2b_queue_drained", 32'(exp_q.size()), 32'd0);

        // reset in the middle of a conversion
        @(negedge clk);
        bus_a.start  = 1'b1;
        bus_a.bin_in = 16'd1234;
        bus_a.dp_en  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        exp_b_q.delete();
        #1;
        check("midreset_bcd", 32'(bus_a.bcd_out), 32'hFFFF);
        check("midreset_busy", 32'(bus_a.busy), 32'd0);
        check("midreset_dp", 32'(bus_a.dp_out), 32'd0);
        check("midreset_ovf", 32'(bus_a.ovf), 32'd0);
        check("midreset_state", 32'(state_a), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        idle(30);
        check("post_reset_busy", 32'(bus_a.busy), 32'd0);
        check("post_reset_bcd", 32'(bus_a.bcd_out), 32'hFFFF);

        // randomized conversions
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 99));
                1:       v = int'($urandom_range(10000, 65535));
                default: v = int'($urandom_range(0, 9999));
            endcase
            run_conv(v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        idle(5);
        check("final_queue_a", 32'(exp_q.size()), 32'd0);
        check("final_queue_b", 32'(exp_b_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
